div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_pkg.sv | 12 +
 rtl/div_abs_neg.sv | 14 +
 rtl/div_seq.sv | 157 +++++++++++++++
 tb/tb_div_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM states and default width.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate. It produces an operand magnitude when
// fed an operand and its sign bit, and restores a result sign when fed a
// magnitude and the wanted sign.
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? -value : value;

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider with signed and unsigned modes. It takes one
// quotient bit per cycle, applies truncating sign correction in a final FIX
// cycle, and short-cuts divide-by-zero straight to FIX.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy,
    output logic             done,
    output logic             zero_division_flag,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out
);

    div_state_e       state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd_raw;     // dividend as given, returned on divide-by-zero
    logic [WIDTH-1:0] dvd_sh;      // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             q_neg;
    logic             r_neg;
    logic             div_zero;

    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   trial_diff;
    logic             trial_ge;
    logic             divisor_zero;

    // Magnitudes only differ from the raw operands in signed mode.
    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (
        .value  (dividend_in),
        .neg    (signed_op & dividend_in[WIDTH-1]),
        .result (dvd_mag_in)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvs (
        .value  (divisor_in),
        .neg    (signed_op & divisor_in[WIDTH-1]),
        .result (dvs_mag_in)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .value  (quo),
        .neg    (q_neg),
        .result (q_fix)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (rem),
        .neg    (r_neg),
        .result (r_fix)
    );

    assign divisor_zero = (divisor_in == '0);

    // Partial remainder is always below the divisor, so one extra bit holds
    // the shifted trial value without overflow.
    assign trial      = {rem, dvd_sh[WIDTH-1]};
    assign trial_diff = trial - {1'b0, dvs_mag};
    assign trial_ge   = (trial >= {1'b0, dvs_mag});

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; flush wins over everything except reset.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state = state;
        busy       = (state != IDLE);
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = divisor_zero ? FIX : CALC;
                CALC:    if (cnt == CNT_W'(1)) next_state = FIX;
                FIX:     next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Datapath: operand capture, one restoring step per CALC cycle, result
    // registration in FIX. Results only change in FIX, so they stay stable
    // between done pulses and survive a flush.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt                <= '0;
            dvd_raw            <= '0;
            dvd_sh             <= '0;
            dvs_mag            <= '0;
            rem                <= '0;
            quo                <= '0;
            q_neg              <= 1'b0;
            r_neg              <= 1'b0;
            div_zero           <= 1'b0;
            done               <= 1'b0;
            zero_division_flag <= 1'b0;
            quotient_out       <= '0;
            remainder_out      <= '0;
        end else begin
            done <= 1'b0;
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            dvd_raw  <= dividend_in;
                            dvd_sh   <= dvd_mag_in;
                            dvs_mag  <= dvs_mag_in;
                            q_neg    <= signed_op & (dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1]);
                            r_neg    <= signed_op & dividend_in[WIDTH-1];
                            div_zero <= divisor_zero;
                            cnt      <= CNT_W'(WIDTH);
                            rem      <= '0;
                            quo      <= '0;
                        end
                    end
                    CALC: begin
                        rem    <= trial_ge ? trial_diff[WIDTH-1:0] : trial[WIDTH-1:0];
                        quo    <= {quo[WIDTH-2:0], trial_ge};
                        dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
                        cnt    <= cnt - CNT_W'(1);
                    end
                    FIX: begin
                        done               <= 1'b1;
                        zero_division_flag <= div_zero;
                        quotient_out       <= div_zero ? '1 : q_fix;
                        remainder_out      <= div_zero ? dvd_raw : r_fix;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: a 32-bit instance driven with directed
// vectors and control scenarios, and an 8-bit instance checked against a
// small reference model. Drivers queue expectations; monitors compare on done.
module tb_div_seq;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        z;
        int          lat;
        int          t0;
        int          id;
    } exp_t;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // 32-bit instance
    logic        d32_start, d32_signed, d32_flush;
    logic [31:0] d32_a, d32_b;
    logic        d32_busy, d32_done, d32_z;
    logic [31:0] d32_q, d32_r;

    // 8-bit instance
    logic        d8_start, d8_signed, d8_flush;
    logic [7:0]  d8_a, d8_b;
    logic        d8_busy, d8_done, d8_z;
    logic [7:0]  d8_q, d8_r;

    div_seq #(.WIDTH(32)) dut32 (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (d32_start),
        .signed_op          (d32_signed),
        .flush              (d32_flush),
        .dividend_in        (d32_a),
        .divisor_in         (d32_b),
        .busy               (d32_busy),
        .done               (d32_done),
        .zero_division_flag (d32_z),
        .quotient_out       (d32_q),
        .remainder_out      (d32_r)
    );

    div_seq #(.WIDTH(8)) dut8 (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (d8_start),
        .signed_op          (d8_signed),
        .flush              (d8_flush),
        .dividend_in        (d8_a),
        .divisor_in         (d8_b),
        .busy               (d8_busy),
        .done               (d8_done),
        .zero_division_flag (d8_z),
        .quotient_out       (d8_q),
        .remainder_out      (d8_r)
    );

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    int   id32 = 0;
    int   id8  = 0;

    // Last result the 32-bit instance should be holding, taken from expectations.
    logic [31:0] prev_q32 = '0;
    logic [31:0] prev_r32 = '0;
    logic        prev_z32 = 1'b0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Truncating reference division for the 8-bit instance.
    function automatic exp_t model8(input logic sg, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   ai, bi, qi, ri;
        e.id = 0;
        e.t0 = 0;
        if (b == 8'h00) begin
            e.q   = 64'hFF;
            e.r   = 64'(a);
            e.z   = 1'b1;
            e.lat = 1;
        end else begin
            ai    = sg ? int'($signed(a)) : int'(a);
            bi    = sg ? int'($signed(b)) : int'(b);
            qi    = ai / bi;
            ri    = ai % bi;
            e.q   = 64'(qi[7:0]);
            e.r   = 64'(ri[7:0]);
            e.z   = 1'b0;
            e.lat = 9;
        end
        return e;
    endfunction

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (reset_n && d32_done) begin
            if (q32.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL d32_unexpected_done: got done=1, required done=0 (cycle %0d)", cyc);
            end else begin
                e32 = q32.pop_front();
                check($sformatf("d32_v%0d_quotient", e32.id), 64'(d32_q), e32.q);
                check($sformatf("d32_v%0d_remainder", e32.id), 64'(d32_r), e32.r);
                check($sformatf("d32_v%0d_zflag", e32.id), 64'(d32_z), 64'(e32.z));
                check($sformatf("d32_v%0d_latency", e32.id), 64'(cyc - e32.t0), 64'(e32.lat));
                prev_q32 = e32.q[31:0];
                prev_r32 = e32.r[31:0];
                prev_z32 = e32.z;
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (reset_n && d8_done) begin
            if (q8.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL d8_unexpected_done: got done=1, required done=0 (cycle %0d)", cyc);
            end else begin
                e8 = q8.pop_front();
                check($sformatf("d8_v%0d_quotient", e8.id), 64'(d8_q), e8.q);
                check($sformatf("d8_v%0d_remainder", e8.id), 64'(d8_r), e8.r);
                check($sformatf("d8_v%0d_zflag", e8.id), 64'(d8_z), 64'(e8.z));
                check($sformatf("d8_v%0d_latency", e8.id), 64'(cyc - e8.t0), 64'(e8.lat));
            end
        end
    end

    // Issue one 32-bit request; called just after a falling edge.
    task automatic go32(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input bit push);
        exp_t e;
        d32_start  = 1'b1;
        d32_signed = sg;
        d32_a      = a;
        d32_b      = b;
        if (push) begin
            e.q   = 64'(eq);
            e.r   = 64'(er);
            e.z   = ez;
            e.lat = ez ? 1 : 33;
            e.t0  = cyc + 1;
            e.id  = id32;
            id32++;
            q32.push_back(e);
        end
        @(negedge clk);
        d32_start = 1'b0;
    endtask

    task automatic go8(input logic sg, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e         = model8(sg, a, b);
        d8_start  = 1'b1;
        d8_signed = sg;
        d8_a      = a;
        d8_b      = b;
        e.t0      = cyc + 1;
        e.id      = id8;
        id8++;
        q8.push_back(e);
        @(negedge clk);
        d8_start = 1'b0;
    endtask

    task automatic drain32(input string nm);
        int k = 0;
        while (q32.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (q32.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results, required 0", nm, q32.size());
            q32.delete();
        end
    endtask

    task automatic drain8(input string nm);
        int k = 0;
        while (q8.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (q8.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results, required 0", nm, q8.size());
            q8.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, required $finish (cycle %0d)", cyc);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        vec_t vecs[10];
        int   k;
        logic sg;
        logic [7:0] ra, rb;

        vecs[0] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h0000_0001, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002, 1'b0};
        vecs[8] = '{1'b1, 32'h0000_0003, 32'h0000_0007, 32'h0000_0000, 32'h0000_0003, 1'b0};
        vecs[9] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE, 1'b0};

        reset_n    = 1'b0;
        d32_start  = 1'b0; d32_signed = 1'b0; d32_flush = 1'b0; d32_a = '0; d32_b = '0;
        d8_start   = 1'b0; d8_signed  = 1'b0; d8_flush  = 1'b0; d8_a  = '0; d8_b  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("reset_busy",      64'(d32_busy), 64'(0));
        check("reset_done",      64'(d32_done), 64'(0));
        check("reset_zflag",     64'(d32_z),    64'(0));
        check("reset_quotient",  64'(d32_q),    64'(0));
        check("reset_remainder", 64'(d32_r),    64'(0));

        // Directed vectors, including divide-by-zero and MIN/-1
        for (int i = 0; i < 10; i++) begin
            go32(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 1'b1);
            check($sformatf("vec%0d_busy_after_start", i), 64'(d32_busy), 64'(1));
            drain32($sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Flush on CALC cycle 10: no done, prior result kept
        go32(1'b0, 32'd1000, 32'd3, '0, '0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        d32_flush = 1'b1;
        @(negedge clk);
        d32_flush = 1'b0;
        check("flush_busy",      64'(d32_busy), 64'(0));
        repeat (40) @(negedge clk);
        check("flush_quotient",  64'(d32_q), 64'(prev_q32));
        check("flush_remainder", 64'(d32_r), 64'(prev_r32));
        check("flush_zflag",     64'(d32_z), 64'(prev_z32));

        // Flush beats start in the same cycle
        d32_flush = 1'b1;
        go32(1'b0, 32'd9, 32'd0, '0, '0, 1'b1, 1'b0);
        d32_flush = 1'b0;
        check("flush_prio_busy", 64'(d32_busy), 64'(0));
        @(negedge clk);
        check("flush_prio_done", 64'(d32_done), 64'(0));
        repeat (3) @(negedge clk);

        // Start while busy is ignored
        go32(1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        go32(1'b0, 32'd99, 32'd0, '0, '0, 1'b1, 1'b0);
        check("busy_ignore_start", 64'(d32_busy), 64'(1));
        drain32("busy_ignore");
        repeat (5) @(negedge clk);

        // Back-to-back: second start in the done cycle
        go32(1'b0, 32'd1000, 32'd7, 32'h0000_008E, 32'd6, 1'b0, 1'b1);
        k = 0;
        while (!d32_done && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("b2b_done_seen", 64'(d32_done), 64'(1));
        go32(1'b1, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, 32'hFFFF_FFFA, 1'b0, 1'b1);
        drain32("b2b");
        repeat (3) @(negedge clk);

        // Reset mid-CALC clears everything
        go32(1'b1, 32'h1234_5678, 32'd13, '0, '0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_busy",      64'(d32_busy), 64'(0));
        check("midreset_done",      64'(d32_done), 64'(0));
        check("midreset_zflag",     64'(d32_z),    64'(0));
        check("midreset_quotient",  64'(d32_q),    64'(0));
        check("midreset_remainder", 64'(d32_r),    64'(0));
        reset_n  = 1'b1;
        prev_q32 = '0;
        prev_r32 = '0;
        prev_z32 = 1'b0;
        repeat (40) @(negedge clk);
        check("midreset_no_done_quotient", 64'(d32_q), 64'(0));

        // WIDTH=8 corner cases then random operands against the model
        go8(1'b1, 8'h80, 8'hFF); drain8("w8_min_neg1");
        go8(1'b0, 8'h80, 8'hFF); drain8("w8_u128_255");
        go8(1'b1, 8'hF3, 8'h00); drain8("w8_zero");
        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = (i % 10 == 3) ? 8'h00 : 8'($urandom);
            go8(sg, ra, rb);
            drain8("w8_rand");
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
